capture_seq: RTL and testbench
==============================

// Module: capture_seq
// PURPOSE
//  Sequences the 5 channel capture RAMs: decimated write strobe, circular write pointer, arming, trigger-position accounting.
//  Runs between the trigger logic and the channel RAMs; reports last-written address and capture completion to command/config.
//  Dump then reads from ram_addr+1 and wraps once around the buffer.
// PARAMETERS
//  ENTRIES  384  depth of each channel RAM (samples)
//  LOG2     9    address width, ceil(log2(ENTRIES))
// PORTS
//  clk               in   1     system clock
//  rst               in   1     synchronous, active-high reset
//  cfg_capture_done  in   1     TrigCfg[5]; 1 = capture held/finished, 0 = host re-arms
//  decimator         in   4     sample every 2^decimator clocks (0 = every clock)
//  trig_pos          in   LOG2  post-trigger sample count ({trig_posH,trig_posL} truncated)
//  triggered         in   1     level from trigger logic; only honoured while armed
//  we                out  1     write strobe to all channel RAMs (one clock per sample)
//  waddr             out  LOG2  write address, valid with we
//  ram_addr          out  LOG2  address of most recent write; stable in DONE
//  armed             out  1     enough pre-trigger samples held; trigger honoured
//  set_capture_done  out  1     one-clock pulse at capture completion
// BEHAVIOUR
//  Reset: state IDLE; we=0, waddr=0, ram_addr=0, armed=0, set_capture_done=0.
//   Sample/post counters and decimation counter = 0.
//  tick: free-running 15-bit dec_cnt. mask=(1<<decimator)-1. tick=((dec_cnt&mask)==mask).
//   dec_cnt clears on IDLE->PRE. Change of decimator mid-capture takes effect next clock, no restart.
//  States:
//   IDLE: wait for cfg_capture_done==0. Then clear smpl_cnt/post_cnt/armed, go PRE. waddr not reset (keeps circulating).
//   PRE: on tick: we=1 at waddr; waddr++ (ENTRIES-1 -> 0); ram_addr<=waddr; smpl_cnt++ (saturates at ENTRIES).
//    armed<=1 once smpl_cnt + trig_pos_eff >= ENTRIES. If armed && triggered: go POST (no write that cycle unless tick).
//   POST: on tick while post_cnt<trig_pos_eff: write as PRE, post_cnt++.
//    When post_cnt==trig_pos_eff: pulse set_capture_done, armed<=0, go DONE.
//    trig_pos_eff==0 -> pulse on the first clock in POST, no post writes.
//   DONE: we=0; ram_addr frozen. Wait for cfg_capture_done==1 (config register set by our pulse), then go IDLE.
//  trig_pos_eff = (trig_pos>=ENTRIES) ? ENTRIES-1 : trig_pos.
//  Trigger asserted before armed is ignored; a still-high trigger is accepted the clock armed rises.
//  cfg_capture_done==1 in PRE/POST (host forced) -> abort to IDLE, no pulse, we=0 that clock.
//  we is combinational from state&tick; waddr/ram_addr/armed/set_capture_done registered.
//  Latency: trigger seen -> first post write on next tick; last post write -> set_capture_done next clock.
//  Reset mid-capture: immediate return to reset values; no pulse.
// CONFIGURATION
//  CAP_DECIM_EN defined: decimation as above.
//  Not defined: decimator ignored, tick=1 every clock, dec_cnt removed.
// STRUCTURE
//  la_pkg: capture state enum (IDLE,PRE,POST,DONE); ENTRIES/LOG2 defaults shared with cmd_cfg and RAM wrappers.
//  Sub-module decim_tick (dec_cnt + mask compare, clear input) under CAP_DECIM_EN; FSM/pointers in capture_seq.
// TESTING
//  Reset, decimator=0, trig_pos=10, triggered=1 from start -> armed after 374 writes.
//   Then 10 post writes, set_capture_done 1 clk, ram_addr=383.
//  decimator=3 -> we exactly every 8 clocks.
//  Same with CAP_DECIM_EN undefined -> we every clock.
//  Pointer wrap: 400 pre samples before trigger -> waddr 383->0 with no gap.
//   ram_addr after done = (400+trig_pos-1) mod 384.
//  trig_pos=0, trigger at arm -> pulse next clock, zero post writes.
//   trig_pos=500 -> behaves as 383 post samples.
//  triggered pulsed while armed=0 -> ignored, no POST.
//   cfg_capture_done forced 1 mid-PRE -> IDLE, no pulse.
//   rst mid-POST -> all outputs 0.

Source files
------------

// File: rtl/la_pkg.sv
// Shared logic-analyser capture definitions: buffer geometry defaults, capture state
// encoding and the decimation mask helper used by capture_seq and decim_tick.
package la_pkg;

   localparam int LA_ENTRIES = 384;
   localparam int LA_LOG2    = 9;
   localparam int LA_DEC_W   = 15;

   typedef enum logic [1:0] {
      CAP_IDLE = 2'd0,
      CAP_PRE  = 2'd1,
      CAP_POST = 2'd2,
      CAP_DONE = 2'd3
   } cap_state_e;

   // Low 'decimator' bits set; a sample is taken when all of them are set in dec_cnt.
   function automatic logic [LA_DEC_W-1:0] dec_mask(input logic [3:0] decimator);
      return (LA_DEC_W'(1) << decimator) - LA_DEC_W'(1);
   endfunction

endpackage

// File: rtl/decim_tick.sv
// Decimation strobe: free-running counter with a synchronous clear, tick once every
// 2^decimator clocks. Only built when CAP_DECIM_EN is defined.
`ifdef CAP_DECIM_EN
module decim_tick
   import la_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       clr,
   input  logic [3:0] decimator,
   output logic       tick
);

   logic [LA_DEC_W-1:0] dec_cnt_q;
   logic [LA_DEC_W-1:0] dec_cnt_d;
   logic [LA_DEC_W-1:0] mask;

   always_comb begin
      mask      = dec_mask(decimator);
      dec_cnt_d = clr ? '0 : dec_cnt_q + LA_DEC_W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         dec_cnt_q <= '0;
      end else begin
         dec_cnt_q <= dec_cnt_d;
      end
   end

   // A new decimator value applies on the very next compare; the count never restarts.
   assign tick = ((dec_cnt_q & mask) == mask);

endmodule
`endif

// File: rtl/capture_seq.sv
// Capture sequencer for the channel RAMs: decimated write strobe, circular write pointer,
// arming and post-trigger accounting. Define CAP_DECIM_EN to enable sample decimation.
module capture_seq
   import la_pkg::*;
#(
   parameter int ENTRIES = LA_ENTRIES,
   parameter int LOG2    = LA_LOG2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            cfg_capture_done,
   input  logic [3:0]      decimator,
   input  logic [LOG2-1:0] trig_pos,
   input  logic            triggered,
   output logic            we,
   output logic [LOG2-1:0] waddr,
   output logic [LOG2-1:0] ram_addr,
   output logic            armed,
   output logic            set_capture_done,
   output cap_state_e      state_dbg
);

   localparam int              CW        = LOG2 + 1;
   localparam logic [CW-1:0]   ENTRIES_C = CW'(ENTRIES);
   localparam logic [LOG2-1:0] LAST_ADDR = LOG2'(ENTRIES - 1);

   cap_state_e      state_q, state_d;
   logic [LOG2-1:0] waddr_q, waddr_d;
   logic [LOG2-1:0] ram_addr_q, ram_addr_d;
   logic [CW-1:0]   smpl_cnt_q, smpl_cnt_d;
   logic [CW-1:0]   post_cnt_q, post_cnt_d;
   logic            armed_q, armed_d;
   logic            set_capture_done_q, set_capture_done_d;

   logic            tick;
   logic            start;
   logic            we_c;
   logic            arm_now;
   logic [LOG2-1:0] waddr_next;
   logic [CW-1:0]   trig_pos_eff;

`ifdef CAP_DECIM_EN
   decim_tick u_decim_tick (
      .clk       (clk),
      .rst       (rst),
      .clr       (start),
      .decimator (decimator),
      .tick      (tick)
   );
`else
   logic unused_decim;
   assign unused_decim = ^{decimator, start};
   assign tick         = 1'b1;
`endif

   // Post-trigger length beyond the buffer depth is clamped to a full buffer minus one.
   assign trig_pos_eff = (CW'(trig_pos) >= ENTRIES_C) ? CW'(LAST_ADDR) : CW'(trig_pos);
   assign waddr_next   = (waddr_q == LAST_ADDR) ? '0 : waddr_q + LOG2'(1);

   always_comb begin
      state_d            = state_q;
      waddr_d            = waddr_q;
      ram_addr_d         = ram_addr_q;
      smpl_cnt_d         = smpl_cnt_q;
      post_cnt_d         = post_cnt_q;
      armed_d            = armed_q;
      set_capture_done_d = 1'b0;
      we_c               = 1'b0;
      start              = 1'b0;
      arm_now            = 1'b0;

      case (state_q)
         CAP_IDLE: begin
            if (!cfg_capture_done) begin
               smpl_cnt_d = '0;
               post_cnt_d = '0;
               armed_d    = 1'b0;
               start      = 1'b1;
               state_d    = CAP_PRE;
            end
         end

         CAP_PRE: begin
            if (cfg_capture_done) begin
               armed_d = 1'b0;
               state_d = CAP_IDLE;
            end else begin
               if (tick) begin
                  we_c       = 1'b1;
                  waddr_d    = waddr_next;
                  ram_addr_d = waddr_q;
                  if (smpl_cnt_q < ENTRIES_C) begin
                     smpl_cnt_d = smpl_cnt_q + CW'(1);
                  end
               end
               // Arming counts the sample written this clock, so a held trigger is taken
               // on the same edge that raises armed.
               arm_now = armed_q | ((smpl_cnt_d + trig_pos_eff) >= ENTRIES_C);
               armed_d = arm_now;
               if (arm_now && triggered) begin
                  state_d = CAP_POST;
               end
            end
         end

         CAP_POST: begin
            if (cfg_capture_done) begin
               armed_d = 1'b0;
               state_d = CAP_IDLE;
            end else begin
               if (tick && (post_cnt_q < trig_pos_eff)) begin
                  we_c       = 1'b1;
                  waddr_d    = waddr_next;
                  ram_addr_d = waddr_q;
                  post_cnt_d = post_cnt_q + CW'(1);
               end
               if (post_cnt_d >= trig_pos_eff) begin
                  set_capture_done_d = 1'b1;
                  armed_d            = 1'b0;
                  state_d            = CAP_DONE;
               end
            end
         end

         CAP_DONE: begin
            if (cfg_capture_done) begin
               state_d = CAP_IDLE;
            end
         end

         default: begin
            state_d = CAP_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q            <= CAP_IDLE;
         waddr_q            <= '0;
         ram_addr_q         <= '0;
         smpl_cnt_q         <= '0;
         post_cnt_q         <= '0;
         armed_q            <= 1'b0;
         set_capture_done_q <= 1'b0;
      end else begin
         state_q            <= state_d;
         waddr_q            <= waddr_d;
         ram_addr_q         <= ram_addr_d;
         smpl_cnt_q         <= smpl_cnt_d;
         post_cnt_q         <= post_cnt_d;
         armed_q            <= armed_d;
         set_capture_done_q <= set_capture_done_d;
      end
   end

   assign we               = we_c & ~rst;
   assign waddr            = waddr_q;
   assign ram_addr         = ram_addr_q;
   assign armed            = armed_q;
   assign set_capture_done = set_capture_done_q;
   assign state_dbg        = state_q;

endmodule

// File: tb/tb_capture_seq.sv
// Bench for capture_seq: directed capture scenarios plus randomized host/trigger traffic,
// all checked every clock against a sample-counting reference model.
module tb_capture_seq;
   import la_pkg::*;

   localparam int E = 384;
   localparam int L = 9;
`ifdef CAP_DECIM_EN
   localparam bit DECIM = 1'b1;
`else
   localparam bit DECIM = 1'b0;
`endif
   localparam int M_IDLE = 0;
   localparam int M_PRE  = 1;
   localparam int M_POST = 2;
   localparam int M_DONE = 3;

   logic         clk;
   logic         rst;
   logic         cfg_capture_done;
   logic [3:0]   decimator;
   logic [L-1:0] trig_pos;
   logic         triggered;
   logic         we;
   logic [L-1:0] waddr;
   logic [L-1:0] ram_addr;
   logic         armed;
   logic         set_capture_done;
   cap_state_e   state_dbg;

   int errors = 0;
   int checks = 0;

   // Reference model: values the registered outputs hold after the next rising edge.
   int m_mode  = M_IDLE;
   int m_waddr = 0;
   int m_ram   = 0;
   int m_held  = 0;
   int m_post  = 0;
   int m_k     = 0;
   bit m_armed = 1'b0;
   bit m_pulse = 1'b0;
   bit m_valid = 1'b0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   capture_seq dut (
      .clk              (clk),
      .rst              (rst),
      .cfg_capture_done (cfg_capture_done),
      .decimator        (decimator),
      .trig_pos         (trig_pos),
      .triggered        (triggered),
      .we               (we),
      .waddr            (waddr),
      .ram_addr         (ram_addr),
      .armed            (armed),
      .set_capture_done (set_capture_done),
      .state_dbg        (state_dbg)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin : model
      int tpe;
      int period;
      bit tk;
      bit ew;
      tpe    = (int'(trig_pos) >= E) ? E - 1 : int'(trig_pos);
      period = DECIM ? (1 << decimator) : 1;
      tk     = (((m_k + 1) % period) == 0);
      ew     = 1'b0;
      if (!rst && !cfg_capture_done) begin
         if (m_mode == M_PRE)  ew = tk;
         if (m_mode == M_POST) ew = tk && (m_post < tpe);
      end
      if (m_valid) begin
         chk("we", we, ew);
         chk("waddr", waddr, m_waddr);
         chk("ram_addr", ram_addr, m_ram);
         chk("armed", armed, m_armed);
         chk("set_capture_done", set_capture_done, m_pulse);
      end
      m_pulse = 1'b0;
      if (rst) begin
         m_mode  = M_IDLE;
         m_waddr = 0;
         m_ram   = 0;
         m_held  = 0;
         m_post  = 0;
         m_k     = 0;
         m_armed = 1'b0;
         m_valid = 1'b1;
      end else begin
         m_k = (m_k + 1) % 32768;
         if (ew) begin
            m_ram   = m_waddr;
            m_waddr = (m_waddr + 1) % E;
            if (m_mode == M_PRE) m_held = (m_held + 1 > E) ? E : m_held + 1;
            else m_post = m_post + 1;
         end
         case (m_mode)
            M_IDLE: if (!cfg_capture_done) begin
               m_held  = 0;
               m_post  = 0;
               m_armed = 1'b0;
               m_k     = 0;
               m_mode  = M_PRE;
            end
            M_PRE: if (cfg_capture_done) begin
               m_armed = 1'b0;
               m_mode  = M_IDLE;
            end else begin
               if (m_held + tpe >= E) m_armed = 1'b1;
               if (m_armed && triggered) m_mode = M_POST;
            end
            M_POST: if (cfg_capture_done) begin
               m_armed = 1'b0;
               m_mode  = M_IDLE;
            end else if (m_post >= tpe) begin
               m_pulse = 1'b1;
               m_armed = 1'b0;
               m_mode  = M_DONE;
            end
            default: if (cfg_capture_done) m_mode = M_IDLE;
         endcase
      end
   end

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst              = 1'b1;
      cfg_capture_done = 1'b1;
      triggered        = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic count_until_armed(output int n);
      int guard;
      guard = 0;
      n     = 0;
      do begin
         @(negedge clk);
         guard++;
         if (!armed && we) n++;
      end while (!armed && guard < 5000);
      chk("armed_reached", armed, 1);
   endtask

   task automatic count_until_done(input int start, output int n);
      int guard;
      guard = 0;
      n     = start;
      do begin
         @(negedge clk);
         guard++;
         if (we) n++;
      end while (!set_capture_done && guard < 5000);
      chk("done_reached", set_capture_done, 1);
   endtask

   task automatic host_ack();
      @(posedge clk);
      #1;
      cfg_capture_done = 1'b1;
      repeat (3) @(posedge clk);
      #1;
   endtask

   initial begin : watchdog
      #3ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int n;
      int nw;
      int last;
      int guard;
      rst              = 1'b1;
      cfg_capture_done = 1'b1;
      decimator        = 4'd0;
      trig_pos         = '0;
      triggered        = 1'b0;

      // Full capture with trigger held from the start.
      do_reset();
      decimator        = 4'd0;
      trig_pos         = 9'd10;
      triggered        = 1'b1;
      cfg_capture_done = 1'b0;
      @(negedge clk);
      chk("rst_waddr", waddr, 0);
      chk("rst_ram_addr", ram_addr, 0);
      chk("rst_armed", armed, 0);
      chk("rst_pulse", set_capture_done, 0);
      chk("rst_state", state_dbg, CAP_IDLE);
      count_until_armed(n);
      chk("pre_writes_tp10", n, 374);
      count_until_done(int'(we), n);
      chk("post_writes_tp10", n, 10);
      chk("ram_addr_tp10", ram_addr, 383);
      @(negedge clk);
      chk("pulse_width", set_capture_done, 0);
      chk("done_hold_state", state_dbg, CAP_DONE);
      chk("done_hold_addr", ram_addr, 383);
      host_ack();

      // Decimation spacing, then a mid-capture decimator change.
      do_reset();
      decimator        = 4'd3;
      trig_pos         = 9'd10;
      cfg_capture_done = 1'b0;
      last = -1;
      nw   = 0;
      for (int c = 0; c < 80; c++) begin
         @(negedge clk);
         if (we) begin
            if (last >= 0) chk("decim_gap", c - last, DECIM ? 8 : 1);
            last = c;
            nw++;
         end
      end
      chk("decim_writes", nw, DECIM ? 9 : 79);
      @(posedge clk);
      #1;
      decimator = 4'd1;
      repeat (40) @(posedge clk);
      host_ack();

      // Pointer wrap: 400 pre-trigger samples.
      do_reset();
      decimator        = 4'd0;
      trig_pos         = 9'd10;
      cfg_capture_done = 1'b0;
      n     = 0;
      guard = 0;
      while (n < 399 && guard < 5000) begin
         @(negedge clk);
         guard++;
         if (we) n++;
      end
      @(posedge clk);
      #1;
      triggered = 1'b1;
      @(negedge clk);
      chk("wrap_trigger_cycle_we", we, 1);
      count_until_done(0, n);
      chk("wrap_post_writes", n, 10);
      chk("wrap_ram_addr", ram_addr, 25);
      host_ack();

      // Zero post-trigger samples.
      do_reset();
      triggered        = 1'b1;
      trig_pos         = 9'd0;
      cfg_capture_done = 1'b0;
      count_until_armed(n);
      chk("pre_writes_tp0", n, 384);
      count_until_done(int'(we), n);
      chk("post_writes_tp0", n, 0);
      chk("ram_addr_tp0", ram_addr, 383);
      host_ack();

      // Oversized trigger position clamps to ENTRIES-1.
      do_reset();
      triggered        = 1'b1;
      trig_pos         = 9'd500;
      cfg_capture_done = 1'b0;
      count_until_armed(n);
      chk("pre_writes_tp500", n, 1);
      count_until_done(int'(we), n);
      chk("post_writes_tp500", n, 383);
      chk("ram_addr_tp500", ram_addr, 383);
      host_ack();

      // Trigger before arming is ignored; host abort from PRE.
      do_reset();
      trig_pos         = 9'd10;
      cfg_capture_done = 1'b0;
      repeat (50) @(posedge clk);
      #1;
      triggered = 1'b1;
      @(posedge clk);
      #1;
      triggered = 1'b0;
      repeat (100) @(negedge clk);
      chk("early_trig_state", state_dbg, CAP_PRE);
      chk("early_trig_armed", armed, 0);
      repeat (350) @(negedge clk);
      chk("late_armed", armed, 1);
      chk("late_state", state_dbg, CAP_PRE);
      @(posedge clk);
      #1;
      cfg_capture_done = 1'b1;
      @(negedge clk);
      chk("abort_we", we, 0);
      @(negedge clk);
      chk("abort_state", state_dbg, CAP_IDLE);
      chk("abort_pulse", set_capture_done, 0);

      // Reset in the middle of POST.
      do_reset();
      trig_pos         = 9'd100;
      triggered        = 1'b1;
      cfg_capture_done = 1'b0;
      guard = 0;
      while (state_dbg != CAP_POST && guard < 2000) begin
         @(negedge clk);
         guard++;
      end
      chk("post_reached", state_dbg, CAP_POST);
      repeat (20) @(posedge clk);
      #1;
      rst = 1'b1;
      @(negedge clk);
      chk("rst_post_we", we, 0);
      @(negedge clk);
      chk("rst_post_waddr", waddr, 0);
      chk("rst_post_ram_addr", ram_addr, 0);
      chk("rst_post_armed", armed, 0);
      chk("rst_post_pulse", set_capture_done, 0);
      chk("rst_post_state", state_dbg, CAP_IDLE);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Randomized traffic; the model process checks every clock.
      for (int i = 0; i < 20000; i++) begin
         @(posedge clk);
         #1;
         if ($urandom_range(0, 299) == 0) decimator = 4'($urandom_range(0, 2));
         if ($urandom_range(0, 199) == 0) trig_pos = L'($urandom_range(0, 511));
         triggered = ($urandom_range(0, 3) == 0);
         if (set_capture_done) cfg_capture_done = 1'b1;
         else if (cfg_capture_done && $urandom_range(0, 15) == 0) cfg_capture_done = 1'b0;
         else if (!cfg_capture_done && $urandom_range(0, 2999) == 0) cfg_capture_done = 1'b1;
         rst = ($urandom_range(0, 4999) == 0);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (2) @(posedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
